// File: rtl/rgbw_spi_master_tx.sv
// SPI mode-0 master transmitter for RGBW lamp command frames.
// Bytes arrive over valid/ready, are shifted MSB first, and cs frames each command.
module rgbw_spi_master_tx #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       sck,
  output logic       mosi,
  output logic       cs,
  output logic       busy,
  output logic [3:0] byte_cnt,
  output logic       done
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [HW-1:0] H_LAST = HW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LEAD = HW'(CLK_DIV);
  localparam logic [GW-1:0] G_LAST = GW'(CS_GAP - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, WAIT, TRAIL, GAP} state_t;

  state_t        state, state_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [2:0]    bcnt, bcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          last, last_n;
  logic          bdone, bdone_n;
  logic          sck_n, mosi_n, cs_n, done_n;
  logic [3:0]    byte_cnt_n;
  logic          accept;

  assign tx_ready = (state == IDLE) || (state == WAIT);
  assign accept   = tx_ready && tx_valid;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      hcnt     <= '0;
      gcnt     <= '0;
      bcnt     <= '0;
      shreg    <= '0;
      last     <= 1'b0;
      bdone    <= 1'b0;
      sck      <= 1'b0;
      mosi     <= 1'b0;
      cs       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
    end else begin
      state    <= state_n;
      hcnt     <= hcnt_n;
      gcnt     <= gcnt_n;
      bcnt     <= bcnt_n;
      shreg    <= shreg_n;
      last     <= last_n;
      bdone    <= bdone_n;
      sck      <= sck_n;
      mosi     <= mosi_n;
      cs       <= cs_n;
      busy     <= (state_n != IDLE);
      done     <= done_n;
      byte_cnt <= byte_cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    hcnt_n     = hcnt;
    gcnt_n     = gcnt;
    bcnt_n     = bcnt;
    shreg_n    = shreg;
    last_n     = last;
    bdone_n    = bdone;
    sck_n      = sck;
    mosi_n     = mosi;
    cs_n       = cs;
    done_n     = 1'b0;
    byte_cnt_n = byte_cnt;
    case (state)
      IDLE, WAIT: begin
        if (accept) begin
          shreg_n = tx_data;
          last_n  = tx_last;
          mosi_n  = tx_data[7];
          hcnt_n  = '0;
          bcnt_n  = '0;
          bdone_n = 1'b0;
          sck_n   = 1'b0;
          cs_n    = 1'b0;
          if (state == IDLE) begin
            state_n    = LEAD;
            byte_cnt_n = '0;
          end else begin
            state_n = SHIFT;
          end
        end
      end
      // Entry cycle plus CLK_DIV sck-low cycles of cs setup before the first rise.
      LEAD: begin
        if (hcnt == H_LEAD) begin
          state_n = SHIFT;
          sck_n   = 1'b1;
          hcnt_n  = '0;
        end else begin
          hcnt_n = hcnt + 1'b1;
        end
      end
      SHIFT: begin
        if (hcnt != H_LAST) begin
          hcnt_n = hcnt + 1'b1;
        end else begin
          hcnt_n = '0;
          if (sck) begin
            sck_n  = 1'b0;
            bcnt_n = bcnt + 1'b1;
            // After the 8th fall mosi keeps bit0 until the next byte is loaded.
            if (bcnt == 3'd7) begin
              bdone_n = 1'b1;
            end else begin
              shreg_n = {shreg[6:0], 1'b0};
              mosi_n  = shreg[6];
            end
          end else if (bdone) begin
            if (byte_cnt != 4'hF) byte_cnt_n = byte_cnt + 1'b1;
            state_n = last ? TRAIL : WAIT;
          end else begin
            sck_n = 1'b1;
          end
        end
      end
      TRAIL: begin
        if (hcnt != H_LAST) begin
          hcnt_n = hcnt + 1'b1;
        end else begin
          state_n = GAP;
          cs_n    = 1'b1;
          done_n  = 1'b1;
          gcnt_n  = '0;
        end
      end
      GAP: begin
        if (gcnt == G_LAST) state_n = IDLE;
        else                gcnt_n  = gcnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_rgbw_spi_master_tx.sv
// Bench for rgbw_spi_master_tx: directed frames, an SPI receiver monitor and a
// scoreboard of expected bytes and frame summaries.
module tb_rgbw_spi_master_tx;
  localparam int CLK_DIV = 4;
  localparam int CS_GAP  = 8;

  logic       clk, reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_last;
  logic       tx_ready, sck, mosi, cs, busy, done;
  logic [3:0] byte_cnt;

  rgbw_spi_master_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_last(tx_last), .tx_ready(tx_ready), .sck(sck), .mosi(mosi), .cs(cs),
    .busy(busy), .byte_cnt(byte_cnt), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nb;
    int cslow;
    int readys;
  } frm_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  frm_t       frm_q[$];
  logic [7:0] fb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // cs-low length of a frame whose source never stalls.
  function automatic int cs_len(input int nb);
    return 1 + CLK_DIV + nb * 16 * CLK_DIV + (nb - 1) * (1 + CLK_DIV) + CLK_DIV;
  endfunction

  // ---------------- monitor ----------------
  int         nbit, rises, cslow, readys, viol, gap_cnt, gap_rdy, hi_cnt;
  logic       have_prev, p_cs, p_sck, p_busy, p_mosi, p_wait, w;
  logic [7:0] sh;
  frm_t       f;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      frm_q.delete();
      nbit = 0; rises = 0; cslow = 0; readys = 0; viol = 0;
      gap_cnt = 0; gap_rdy = 0; hi_cnt = 0; have_prev = 1'b0;
      p_cs = 1'b1; p_sck = 1'b0; p_busy = 1'b0; p_mosi = 1'b0; p_wait = 1'b0;
      sh = '0;
    end else begin
      w = !cs && tx_ready;
      if (!cs && p_cs) begin
        if (have_prev) chk("cs_gap_min", 32'(hi_cnt >= CS_GAP), 1);
        cslow = 0; rises = 0; readys = 0; viol = 0;
      end
      if (sck && !p_sck) begin
        rises++;
        sh = {sh[6:0], mosi};
        nbit++;
        if (nbit == 8) begin
          nbit = 0;
          chk("byte_pending", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) chk("rx_byte", 32'(sh), 32'(exp_q.pop_front()));
        end
      end
      if (sck && p_sck && mosi != p_mosi) viol++;
      if (w && p_wait && (sck || mosi != p_mosi)) viol++;
      if (!cs) begin
        cslow++;
        if (tx_ready) readys++;
      end else begin
        if (!p_cs) hi_cnt = 0;
        hi_cnt++;
      end
      if (busy && cs) begin
        gap_cnt++;
        if (tx_ready) gap_rdy++;
      end
      if (p_busy && !busy) begin
        chk("gap_len", 32'(gap_cnt), 32'(CS_GAP));
        chk("gap_ready", 32'(gap_rdy), 0);
        gap_cnt = 0; gap_rdy = 0;
      end
      if (done) begin
        chk("done_at_cs_rise", 32'({cs, p_cs}), 32'(2'b10));
        chk("frame_pending", 32'(frm_q.size() != 0), 1);
        if (frm_q.size() != 0) begin
          f = frm_q.pop_front();
          chk("byte_cnt", 32'(byte_cnt), 32'(f.nb > 15 ? 15 : f.nb));
          chk("sck_rises", 32'(rises), 32'(8 * f.nb));
          chk("bit_align", 32'(nbit), 0);
          chk("sck_mosi_viol", 32'(viol), 0);
          if (f.cslow >= 0) chk("cs_low_len", 32'(cslow), 32'(f.cslow));
          if (f.readys >= 0) chk("wait_ready_cycles", 32'(readys), 32'(f.readys));
        end
        have_prev = 1'b1;
      end
      p_cs = cs; p_sck = sck; p_busy = busy; p_mosi = mosi; p_wait = w;
    end
  end

  // ---------------- driver ----------------
  task automatic send_byte(input logic [7:0] d, input logic l);
    int   n;
    logic acc;
    n = 0; acc = 1'b0;
    tx_data = d; tx_last = l; tx_valid = 1'b1;
    while (!acc && n < 2000) begin
      @(negedge clk);
      acc = tx_ready;
      n++;
      @(posedge clk); #1;
    end
    chk("accept", 32'(acc), 1);
  endtask

  task automatic push_frame(input int nb, input int csl, input int rdy);
    frm_t fr;
    fr.nb = nb; fr.cslow = csl; fr.readys = rdy;
    frm_q.push_back(fr);
  endtask

  task automatic send_frame();
    push_frame(fb.size(), cs_len(fb.size()), fb.size() - 1);
    foreach (fb[i]) exp_q.push_back(fb[i]);
    foreach (fb[i]) send_byte(fb[i], i == fb.size() - 1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 32'(busy), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n, nr, nd;
    logic ps, seen;
    reset = 1'b0; tx_data = '0; tx_valid = 1'b0; tx_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(cs), 1);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_byte_cnt", 32'(byte_cnt), 0);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // single-byte frame
    fb = '{8'hA5};
    send_frame();
    wait_idle();

    // multi-byte frame, source never stalls
    fb = '{8'h01, 8'hFF, 8'h00, 8'h80};
    send_frame();
    wait_idle();

    // source stalls in WAIT for 20 cycles after byte 1
    push_frame(2, -1, -1);
    exp_q.push_back(8'h3D);
    exp_q.push_back(8'h5A);
    send_byte(8'h3D, 1'b0);
    tx_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 500) begin
      @(negedge clk);
      seen = !cs && tx_ready;
      n++;
    end
    chk("reach_wait", 32'(seen), 1);
    repeat (20) @(negedge clk);
    chk("stall_sck", 32'(sck), 0);
    chk("stall_cs", 32'(cs), 0);
    chk("stall_mosi_bit0", 32'(mosi), 1);
    @(posedge clk); #1;
    send_byte(8'h5A, 1'b1);
    tx_valid = 1'b0;
    wait_idle();

    // back-to-back frames exercise the cs gap
    fb = '{8'h11};
    send_frame();
    fb = '{8'h22};
    send_frame();
    wait_idle();

    // 17 bytes: byte_cnt sticks at 15
    fb.delete();
    for (int i = 0; i < 17; i++) fb.push_back(8'(i * 13 + 1));
    send_frame();
    wait_idle();

    // lamp command: mode, white, R, G, B
    fb = '{8'h02, 8'h7F, 8'h12, 8'h34, 8'h56};
    send_frame();
    wait_idle();

    // reset during the 3rd bit of a byte
    push_frame(1, -1, -1);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    tx_valid = 1'b0;
    nr = 0; n = 0; ps = sck;
    while (nr < 3 && n < 500) begin
      @(negedge clk);
      if (sck && !ps) nr++;
      ps = sck;
      n++;
    end
    chk("third_bit_seen", 32'(nr), 3);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cs", 32'(cs), 1);
    chk("mid_rst_sck", 32'(sck), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_byte_cnt", 32'(byte_cnt), 0);
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_tx_ready", 32'(tx_ready), 1);
    reset = 1'b1;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("no_done_after_rst", 32'(nd), 0);
    @(posedge clk); #1;

    // recovery after abort
    fb = '{8'h96};
    send_frame();
    wait_idle();

    repeat (5) @(posedge clk);
    chk("bytes_all_seen", 32'(exp_q.size()), 0);
    chk("frames_all_seen", 32'(frm_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
